// File: rtl/ldpc_dvb_dec_pcheck_pkg.sv
// Shared DVB-S2 LDPC decoder constants and types used by the parity-check block.
// Expansion factor, lane word, strobe pair and row index for q <= 135.
package ldpc_dvb_dec_pcheck_pkg;

    localparam int cZC_MAX = 360;
    localparam int cROW_W  = 8;
    localparam int cPOP_W  = $clog2(cZC_MAX + 1);

    typedef logic [cZC_MAX-1:0] zdat_t;
    typedef logic [cROW_W-1:0]  row_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } strb_t;

endpackage

// File: rtl/ldpc_dvb_dec_pcheck_popcnt.sv
// Registered population count of one cZC_MAX-bit lane word, one cycle latency.
// Bytes are counted first, then the byte counts are summed.
module ldpc_dvb_dec_pcheck_popcnt
    import ldpc_dvb_dec_pcheck_pkg::*;
(
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  zdat_t             idat,
    output logic [cPOP_W-1:0] ocnt
);

    localparam int cGRP_W = 8;
    localparam int cNGRP  = cZC_MAX / cGRP_W;

    logic [3:0]        grp_cnt [cNGRP];
    logic [cPOP_W-1:0] cnt_d;
    logic [cPOP_W-1:0] cnt_q;

    always_comb begin
        for (int g = 0; g < cNGRP; g++) begin
            grp_cnt[g] = '0;
            for (int b = 0; b < cGRP_W; b++) begin
                grp_cnt[g] = grp_cnt[g] + 4'(idat[g*cGRP_W + b]);
            end
        end
        cnt_d = '0;
        for (int g = 0; g < cNGRP; g++) begin
            cnt_d = cnt_d + cPOP_W'(grp_cnt[g]);
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            cnt_q <= '0;
        end else if (iclkena) begin
            cnt_q <= cnt_d;
        end
    end

    assign ocnt = cnt_q;

endmodule

// File: rtl/ldpc_dvb_dec_pcheck.sv
// DVB-S2 IRA decoder parity check: per-row syndrome, frame fail flag and syndrome weight.
// Define LDPC_DVB_DEC_PCHECK_ERRCNT_EN to build the popcount and weight accumulator.
module ldpc_dvb_dec_pcheck
    import ldpc_dvb_dec_pcheck_pkg::*;
#(
    parameter int pERR_W = 16
)
(
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  logic              istart,
    input  logic              ival,
    input  strb_t             istrb,
    input  zdat_t             iinfo,
    input  zdat_t             ipar,
    output logic              osynd_val,
    output row_t              osynd_row_idx,
    output zdat_t             osynd,
    output logic              oval,
    output logic              odecfail,
    output logic [pERR_W-1:0] oerr_cnt
);

    logic  unused_sop;
    logic  accept;

    row_t  row_q, row_d;
    logic  done_q, done_d;
    logic  fin_pend_q, fin_pend_d;
    zdat_t prev_par_q, prev_par_d;
    zdat_t partial_q, partial_d;

    logic  synd_val_q, synd_val_d;
    zdat_t synd_q, synd_d;
    row_t  synd_idx_q, synd_idx_d;
    logic  synd_last_q, synd_last_d;

    logic  chk_val_q, chk_val_d;
    logic  chk_last_q, chk_last_d;
    logic  chk_nz;

    logic  fail_q, fail_d;
    logic  oval_q, oval_d;

    assign unused_sop = istrb.sop;
    assign accept     = ival & ~done_q;

    // Row 0 needs the last row's parity, so it is held as a partial word and emitted after eop.
    always_comb begin
        row_d       = row_q;
        done_d      = done_q;
        fin_pend_d  = 1'b0;
        prev_par_d  = prev_par_q;
        partial_d   = partial_q;
        synd_val_d  = 1'b0;
        synd_d      = synd_q;
        synd_idx_d  = synd_idx_q;
        synd_last_d = 1'b0;
        if (istart) begin
            row_d  = '0;
            done_d = 1'b0;
        end else if (fin_pend_q) begin
            synd_val_d  = 1'b1;
            synd_d      = partial_q ^ {prev_par_q[cZC_MAX-2:0], 1'b0};
            synd_idx_d  = '0;
            synd_last_d = 1'b1;
        end else if (accept) begin
            prev_par_d = ipar;
            row_d      = row_q + row_t'(1);
            if (row_q == '0) begin
                partial_d = iinfo ^ ipar;
            end else begin
                synd_val_d = 1'b1;
                synd_d     = iinfo ^ ipar ^ prev_par_q;
                synd_idx_d = row_q;
            end
            if (istrb.eop) begin
                done_d     = 1'b1;
                fin_pend_d = 1'b1;
            end
        end
    end

    assign chk_val_d  = synd_val_q & ~istart;
    assign chk_last_d = synd_val_q & synd_last_q & ~istart;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            row_q       <= '0;
            done_q      <= 1'b0;
            fin_pend_q  <= 1'b0;
            prev_par_q  <= '0;
            partial_q   <= '0;
            synd_val_q  <= 1'b0;
            synd_q      <= '0;
            synd_idx_q  <= '0;
            synd_last_q <= 1'b0;
            chk_val_q   <= 1'b0;
            chk_last_q  <= 1'b0;
            fail_q      <= 1'b0;
            oval_q      <= 1'b0;
        end else if (iclkena) begin
            row_q       <= row_d;
            done_q      <= done_d;
            fin_pend_q  <= fin_pend_d;
            prev_par_q  <= prev_par_d;
            partial_q   <= partial_d;
            synd_val_q  <= synd_val_d;
            synd_q      <= synd_d;
            synd_idx_q  <= synd_idx_d;
            synd_last_q <= synd_last_d;
            chk_val_q   <= chk_val_d;
            chk_last_q  <= chk_last_d;
            fail_q      <= fail_d;
            oval_q      <= oval_d;
        end
    end

`ifdef LDPC_DVB_DEC_PCHECK_ERRCNT_EN
    localparam int cSUM_W = pERR_W + 1;

    logic [cPOP_W-1:0] pc_cnt;
    logic [cSUM_W-1:0] err_sum;
    logic [pERR_W-1:0] err_cnt_q, err_cnt_d;

    ldpc_dvb_dec_pcheck_popcnt u_popcnt (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .iclkena  (iclkena),
        .idat     (synd_q),
        .ocnt     (pc_cnt)
    );

    assign chk_nz = |pc_cnt;

    // Saturating weight accumulator, cleared by frame start.
    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + cSUM_W'(pc_cnt);
        err_cnt_d = err_cnt_q;
        if (istart) begin
            err_cnt_d = '0;
        end else if (chk_val_q) begin
            err_cnt_d = err_sum[pERR_W] ? '1 : err_sum[pERR_W-1:0];
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            err_cnt_q <= '0;
        end else if (iclkena) begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign oerr_cnt = err_cnt_q;
`else
    logic nz_q;

    // OR-reduce stage stands in for the popcount so oval timing is unchanged.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            nz_q <= 1'b0;
        end else if (iclkena) begin
            nz_q <= |synd_q;
        end
    end

    assign chk_nz   = nz_q;
    assign oerr_cnt = '0;
`endif

    always_comb begin
        fail_d = fail_q;
        oval_d = 1'b0;
        if (istart) begin
            fail_d = 1'b0;
        end else begin
            oval_d = chk_last_q;
            if (chk_val_q) begin
                fail_d = fail_q | chk_nz;
            end
        end
    end

    assign osynd_val     = synd_val_q;
    assign osynd_row_idx = synd_idx_q;
    assign osynd         = synd_q;
    assign oval          = oval_q;
    assign odecfail      = fail_q;

endmodule
